// File: rtl/serial_pattern_detector_pkg.sv
// Shared types and default widths for the serial pattern detector slice.
package serial_pattern_detector_pkg;

  localparam int SPD_PAT_W = 4;
  localparam int SPD_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HUNT = 2'd2
  } spd_state_e;

endpackage

// File: rtl/serial_pattern_detector_if.sv
// Bit-stream, control and observation bundle between a stream source and the detector.
interface serial_pattern_detector_if
  import serial_pattern_detector_pkg::*;
#(
  parameter int PAT_W = SPD_PAT_W,
  parameter int CNT_W = SPD_CNT_W
);

  logic             bit_valid;
  logic             bit_in;
  logic [PAT_W-1:0] pattern_in;
  logic             pattern_load;
  logic             overlap_en;
  logic             clear;
  logic             detect;
  logic [CNT_W-1:0] match_count;
  logic [PAT_W-1:0] history;
  logic             armed;

  modport master (
    output bit_valid, bit_in, pattern_in, pattern_load, overlap_en, clear,
    input  detect, match_count, history, armed
  );

  modport slave (
    input  bit_valid, bit_in, pattern_in, pattern_load, overlap_en, clear,
    output detect, match_count, history, armed
  );

endinterface

// File: rtl/serial_pattern_detector_sat_counter.sv
// Saturating up-counter with a clear that takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear beats increment, holds once all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q = cnt_r;

endmodule

// File: rtl/serial_pattern_detector.sv
// Detects a programmable PAT_W-bit pattern (MSB first) in a serial stream, with optional overlap.
module serial_pattern_detector
  import serial_pattern_detector_pkg::*;
#(
  parameter int PAT_W = SPD_PAT_W,
  parameter int CNT_W = SPD_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_pattern_detector_if.slave bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_ZERO = FILL_W'(0);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  spd_state_e       state_r;
  spd_state_e       state_nxt_s;
  logic [PAT_W-1:0] pattern_r;
  logic [PAT_W-1:0] pattern_nxt_s;
  logic [PAT_W-1:0] history_r;
  logic [PAT_W-1:0] history_nxt_s;
  logic [PAT_W-1:0] shift_s;
  logic [FILL_W-1:0] fill_cnt_r;
  logic [FILL_W-1:0] fill_nxt_s;
  logic             detect_r;
  logic             armed_r;
  logic             match_s;
  logic [CNT_W-1:0] count_s;

  assign shift_s = {history_r[PAT_W-2:0], bus.bit_in};

  // Next-state, shifter and comparator; a load pre-empts any bit on the same cycle.
  always_comb begin
    state_nxt_s   = state_r;
    pattern_nxt_s = pattern_r;
    history_nxt_s = history_r;
    fill_nxt_s    = fill_cnt_r;
    match_s       = 1'b0;
    if (bus.pattern_load) begin
      pattern_nxt_s = bus.pattern_in;
      history_nxt_s = {PAT_W{1'b0}};
      fill_nxt_s    = FILL_ZERO;
      state_nxt_s   = S_FILL;
    end else if (bus.bit_valid) begin
      case (state_r)
        S_IDLE: begin
          state_nxt_s = S_IDLE;
        end
        S_FILL, S_HUNT: begin
          history_nxt_s = shift_s;
          fill_nxt_s    = (fill_cnt_r == FILL_FULL) ? FILL_FULL : (fill_cnt_r + FILL_ONE);
          if ((fill_cnt_r >= FILL_LAST) && (shift_s == pattern_r)) begin
            match_s = 1'b1;
            if (bus.overlap_en) begin
              state_nxt_s = S_HUNT;
            end else begin
              history_nxt_s = {PAT_W{1'b0}};
              fill_nxt_s    = FILL_ZERO;
              state_nxt_s   = S_FILL;
            end
          end else if (fill_cnt_r >= FILL_LAST) begin
            state_nxt_s = S_HUNT;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: begin
          history_nxt_s = {PAT_W{1'b0}};
          fill_nxt_s    = FILL_ZERO;
          state_nxt_s   = S_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, pattern, history and registered output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      pattern_r  <= {PAT_W{1'b0}};
      history_r  <= {PAT_W{1'b0}};
      fill_cnt_r <= FILL_ZERO;
      detect_r   <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pattern_r  <= pattern_nxt_s;
      history_r  <= history_nxt_s;
      fill_cnt_r <= fill_nxt_s;
      detect_r   <= match_s;
      armed_r    <= (state_nxt_s != S_IDLE);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match_s),
    .clr (bus.clear),
    .q   (count_s)
  );

  assign bus.detect      = detect_r;
  assign bus.match_count = count_s;
  assign bus.history     = history_r;
  assign bus.armed       = armed_r;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Table-driven scoreboard bench; a CNT_W=2 twin shares the stimulus to exercise saturation.
module tb_serial_pattern_detector;

  logic clk;
  logic rst;

  serial_pattern_detector_if #(.PAT_W(4), .CNT_W(8)) if8 ();
  serial_pattern_detector_if #(.PAT_W(4), .CNT_W(2)) if2 ();

  serial_pattern_detector #(.PAT_W(4), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_pattern_detector #(.PAT_W(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    string      name;
    logic       rst, vld, b, load;
    logic [3:0] pat;
    logic       ovl, clr;
    logic       det;
    logic [7:0] cnt;
    logic [3:0] hist;
    logic       arm;
  } vec_t;

  typedef struct {
    string      name;
    logic       det;
    logic [7:0] cnt;
    logic [3:0] hist;
    logic       arm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string nm, input logic r, input logic v, input logic b, input logic ld,
                     input logic [3:0] p, input logic ov, input logic cl, input logic dt,
                     input logic [7:0] c, input logic [3:0] h, input logic ar);
    vec_t t;
    t.name = nm; t.rst = r; t.vld = v; t.b = b; t.load = ld; t.pat = p; t.ovl = ov; t.clr = cl;
    t.det = dt; t.cnt = c; t.hist = h; t.arm = ar;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", nm, got, expv);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic b, input logic ld,
                       input logic [3:0] p, input logic ov, input logic cl);
    @(negedge clk);
    rst = r;
    if8.bit_valid = v;  if2.bit_valid = v;
    if8.bit_in = b;     if2.bit_in = b;
    if8.pattern_load = ld; if2.pattern_load = ld;
    if8.pattern_in = p; if2.pattern_in = p;
    if8.overlap_en = ov; if2.overlap_en = ov;
    if8.clear = cl;     if2.clear = cl;
  endtask

  task automatic push_exp(input string nm, input logic dt, input logic [7:0] c,
                          input logic [3:0] h, input logic ar);
    exp_t e;
    e.name = nm; e.det = dt; e.cnt = c; e.hist = h; e.arm = ar;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [7:0] c2;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty got 0 entries expected 1");
    end else begin
      e  = sb.pop_front();
      c2 = (e.cnt > 8'd3) ? 8'd3 : e.cnt;
      chk({e.name, ".det"},  32'(if8.detect),      32'(e.det));
      chk({e.name, ".cnt"},  32'(if8.match_count), 32'(e.cnt));
      chk({e.name, ".hist"}, 32'(if8.history),     32'(e.hist));
      chk({e.name, ".arm"},  32'(if8.armed),       32'(e.arm));
      chk({e.name, ".det2"}, 32'(if2.detect),      32'(e.det));
      chk({e.name, ".cnt2"}, 32'(if2.match_count), 32'(c2));
    end
  endtask

  initial begin
    logic [3:0]  p;
    logic [18:0] s5;
    logic [3:0]  h;
    logic [7:0]  c;
    logic        d;

    p = 4'b1011;
    rst = 1'b1;
    if8.bit_valid = 1'b0; if2.bit_valid = 1'b0;
    if8.bit_in = 1'b0;    if2.bit_in = 1'b0;
    if8.pattern_load = 1'b0; if2.pattern_load = 1'b0;
    if8.pattern_in = 4'h0; if2.pattern_in = 4'h0;
    if8.overlap_en = 1'b0; if2.overlap_en = 1'b0;
    if8.clear = 1'b0;     if2.clear = 1'b0;

    // Unarmed after reset: bits are ignored.
    add("t1_rst",  1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    add("t1_b1",   1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    add("t1_b2",   1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    add("t1_b3",   1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    add("t1_b4",   1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    // Overlapping: 1011011.
    add("t2_load", 1'b0, 1'b0, 1'b0, 1'b1, p, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, 1'b1);
    add("t2_b1",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, 1'b1);
    add("t2_b2",   1'b0, 1'b1, 1'b0, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0010, 1'b1);
    add("t2_b3",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0101, 1'b1);
    add("t2_b4",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b1, 8'd1, 4'b1011, 1'b1);
    add("t2_b5",   1'b0, 1'b1, 1'b0, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0110, 1'b1);
    add("t2_b6",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd1, 4'b1101, 1'b1);
    add("t2_b7",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b1, 8'd2, 4'b1011, 1'b1);
    add("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd2, 4'b1011, 1'b1);
    // Non-overlapping, count cleared at the load.
    add("t3_load", 1'b0, 1'b0, 1'b0, 1'b1, p, 1'b0, 1'b1, 1'b0, 8'd0, 4'b0000, 1'b1);
    add("t3_b1",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0001, 1'b1);
    add("t3_b2",   1'b0, 1'b1, 1'b0, 1'b0, p, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0010, 1'b1);
    add("t3_b3",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0101, 1'b1);
    add("t3_b4",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b0, 1'b0, 1'b1, 8'd1, 4'b0000, 1'b1);
    add("t3_b5",   1'b0, 1'b1, 1'b0, 1'b0, p, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0000, 1'b1);
    add("t3_b6",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0001, 1'b1);
    add("t3_b7",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0011, 1'b1);
    // bit_valid gaps hold the search.
    add("t4_load", 1'b0, 1'b0, 1'b0, 1'b1, p, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0000, 1'b1);
    add("t4_b1",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0001, 1'b1);
    add("t4_b2",   1'b0, 1'b1, 1'b0, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0010, 1'b1);
    add("t4_gap1", 1'b0, 1'b0, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0010, 1'b1);
    add("t4_gap2", 1'b0, 1'b0, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0010, 1'b1);
    add("t4_gap3", 1'b0, 1'b0, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0010, 1'b1);
    add("t4_b3",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0101, 1'b1);
    add("t4_b4",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b1, 8'd2, 4'b1011, 1'b1);
    add("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd2, 4'b1011, 1'b1);
    // Six matches; clear lands on the sixth.
    add("t5_clr",  1'b0, 1'b0, 1'b0, 1'b0, p, 1'b1, 1'b1, 1'b0, 8'd0, 4'b1011, 1'b1);
    add("t5_load", 1'b0, 1'b0, 1'b0, 1'b1, p, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, 1'b1);
    s5 = 19'b1011011011011011011;
    h = 4'b0000;
    c = 8'd0;
    for (int k = 0; k < 19; k++) begin
      h = {h[2:0], s5[18-k]};
      d = (k >= 3) && (((k - 3) % 3) == 0);
      if (k == 18) c = 8'd0;
      else if (d) c = c + 8'd1;
      else c = c;
      add($sformatf("t5_b%0d", k + 1), 1'b0, 1'b1, s5[18-k], 1'b0, p, 1'b1, (k == 18), d, c, h, 1'b1);
    end
    // Load mid-stream drops the coincident bit; reset mid-hunt.
    add("t6_b1",   1'b0, 1'b1, 1'b1, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0111, 1'b1);
    add("t6_b2",   1'b0, 1'b1, 1'b0, 1'b0, p, 1'b1, 1'b0, 1'b0, 8'd0, 4'b1110, 1'b1);
    add("t6_load", 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, 1'b1);
    add("t6_n1",   1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, 1'b1);
    add("t6_n2",   1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, 1'b1);
    add("t6_n3",   1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0011, 1'b1);
    add("t6_n4",   1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b1, 8'd1, 4'b0110, 1'b1);
    add("t6_n5",   1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd1, 4'b1101, 1'b1);
    add("t6_rst",  1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, 1'b0);
    add("t6_post", 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].b, vecs[i].load, vecs[i].pat, vecs[i].ovl, vecs[i].clr);
      push_exp(vecs[i].name, vecs[i].det, vecs[i].cnt, vecs[i].hist, vecs[i].arm);
      check_out();
    end

    // Long run of ones against 1111 drives the 8-bit count into saturation.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
    push_exp("sat_load", 1'b0, 8'd0, 4'b0000, 1'b1);
    check_out();
    for (int i = 1; i <= 300; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
      c = (i < 4) ? 8'd0 : ((i - 3) > 255 ? 8'd255 : 8'(i - 3));
      h = (i >= 4) ? 4'b1111 : 4'((1 << i) - 1);
      push_exp($sformatf("sat_b%0d", i), (i >= 4), c, h, 1'b1);
      check_out();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
